// File: rtl/cpu.sv
// Multi-cycle 16-bit RISC core: eight general registers, shifter/ALU datapath,
// 3-bit status register and a single memory port shared by fetch and load/store.
module cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [8:0]  mem_addr,
    output logic [1:0]  mem_cmd,
    input  logic [15:0] read_data,
    output logic [15:0] write_data,
    output logic        HALTLED
);
    localparam logic [3:0] S_RST   = 4'd0;
    localparam logic [3:0] S_IF1   = 4'd1;
    localparam logic [3:0] S_IF2   = 4'd2;
    localparam logic [3:0] S_UPC   = 4'd3;
    localparam logic [3:0] S_DEC   = 4'd4;
    localparam logic [3:0] S_WIMM  = 4'd5;
    localparam logic [3:0] S_GETA  = 4'd6;
    localparam logic [3:0] S_GETB  = 4'd7;
    localparam logic [3:0] S_EXEC  = 4'd8;
    localparam logic [3:0] S_WR    = 4'd9;
    localparam logic [3:0] S_ADDR  = 4'd10;
    localparam logic [3:0] S_MEMRD = 4'd11;
    localparam logic [3:0] S_WRLD  = 4'd12;
    localparam logic [3:0] S_MEMWR = 4'd13;
    localparam logic [3:0] S_HALT  = 4'd14;

    logic [3:0]  state;
    logic [8:0]  pc;
    logic [8:0]  data_addr;
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [2:0]  Z;
    logic [15:0] regs [0:7];

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] imm8_sx;
    logic [15:0] imm5_sx;
    logic        is_movi;
    logic        is_mov;
    logic        is_alu;
    logic        is_cmp;
    logic        is_ldr;
    logic        is_str;
    logic [15:0] shifted;
    logic [15:0] alu_out;
    logic [15:0] addr_sum;
    logic        cmp_overflow;

    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign imm8_sx = {{8{ir[7]}}, ir[7:0]};
    assign imm5_sx = {{11{ir[4]}}, ir[4:0]};

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov  = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);

    always_comb begin
        shifted = b;
        case (sh)
            2'b01:   shifted = {b[14:0], 1'b0};
            2'b10:   shifted = {1'b0, b[15:1]};
            2'b11:   shifted = {b[15], b[15:1]};
            default: shifted = b;
        endcase
    end

    // Register MOV reuses the adder path: A is forced to zero in GETA.
    always_comb begin
        alu_out = a + shifted;
        if (is_alu) begin
            case (op)
                2'b01:   alu_out = a - shifted;
                2'b10:   alu_out = a & shifted;
                2'b11:   alu_out = ~shifted;
                default: alu_out = a + shifted;
            endcase
        end
    end

    assign addr_sum     = a + imm5_sx;
    assign cmp_overflow = (a[15] != shifted[15]) && (alu_out[15] != a[15]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST;
            pc        <= '0;
            data_addr <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            Z         <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_RST: state <= S_IF1;
                S_IF1: state <= S_IF2;
                S_IF2: begin
                    ir    <= read_data;
                    state <= S_UPC;
                end
                S_UPC: begin
                    pc    <= pc + 9'd1;
                    state <= S_DEC;
                end
                S_DEC: begin
                    if (is_movi)                               state <= S_WIMM;
                    else if (is_mov || is_alu || is_ldr || is_str) state <= S_GETA;
                    else                                       state <= S_HALT;
                end
                S_WIMM: begin
                    regs[rn] <= imm8_sx;
                    state    <= S_IF1;
                end
                S_GETA: begin
                    a     <= is_mov ? 16'd0 : regs[rn];
                    state <= (is_ldr || is_str) ? S_ADDR : S_GETB;
                end
                S_GETB: begin
                    // A store fetches its data register here and parks it in C for the bus.
                    if (is_str) begin
                        b     <= regs[rd];
                        c     <= regs[rd];
                        state <= S_MEMWR;
                    end else begin
                        b     <= regs[rm];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    c <= alu_out;
                    if (is_cmp) Z <= {cmp_overflow, alu_out[15], (alu_out == 16'd0)};
                    state <= S_WR;
                end
                S_WR: begin
                    if (!is_cmp) regs[rd] <= c;
                    state <= S_IF1;
                end
                S_ADDR: begin
                    c         <= addr_sum;
                    data_addr <= addr_sum[8:0];
                    state     <= is_ldr ? S_MEMRD : S_GETB;
                end
                S_MEMRD: state <= S_WRLD;
                S_WRLD: begin
                    regs[rd] <= read_data;
                    state    <= S_IF1;
                end
                S_MEMWR: state <= S_IF1;
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_IF1, S_IF2, S_MEMRD, S_WRLD: mem_cmd = 2'b01;
            S_MEMWR:                       mem_cmd = 2'b10;
            default:                       mem_cmd = 2'b00;
        endcase
    end

    assign mem_addr   = (state == S_MEMRD || state == S_WRLD || state == S_MEMWR) ? data_addr : pc;
    assign write_data = c;
    assign HALTLED    = (state == S_HALT);
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: a word memory model drives read_data, and an instruction-level
// reference model predicts bus activity, C and status for every instruction.
module tb_cpu;
    logic        clk;
    logic        reset;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] read_data;
    logic [15:0] write_data;
    logic        HALTLED;

    cpu dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_cmd    (mem_cmd),
        .read_data  (read_data),
        .write_data (write_data),
        .HALTLED    (HALTLED)
    );

    // Clock and memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:511];
    assign read_data = mem[mem_addr];

    // Reference model state
    logic [15:0] ref_mem  [0:511];
    logic [15:0] ref_regs [0:7];
    int          ref_pc;
    logic [15:0] ref_c;
    logic [2:0]  ref_z;
    logic        ref_halt;

    int checks;
    int errors;

    localparam int K_MOVI = 0;
    localparam int K_ALU  = 1;
    localparam int K_LDR  = 2;
    localparam int K_STR  = 3;
    localparam int K_HALT = 4;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_movi(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction
    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [2:0] rn,
                                            input logic [2:0] rd, input logic [1:0] sh,
                                            input logic [2:0] rm);
        return {3'b101, op, rn, rd, sh, rm};
    endfunction
    function automatic logic [15:0] enc_mov(input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] rm);
        return {3'b110, 2'b00, 3'b000, rd, sh, rm};
    endfunction
    function automatic logic [15:0] enc_ldr(input logic [2:0] rn, input logic [2:0] rd, input logic [4:0] imm);
        return {3'b011, 2'b00, rn, rd, imm};
    endfunction
    function automatic logic [15:0] enc_str(input logic [2:0] rn, input logic [2:0] rd, input logic [4:0] imm);
        return {3'b100, 2'b00, rn, rd, imm};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [2:0] r1, r2, r3;
        logic [1:0] s, o;
        int k;
        r1 = 3'($urandom_range(0, 7));
        r2 = 3'($urandom_range(0, 7));
        r3 = 3'($urandom_range(0, 7));
        s  = 2'($urandom_range(0, 3));
        o  = 2'($urandom_range(0, 3));
        k  = $urandom_range(0, 9);
        if (k <= 2)      return enc_movi(r1, 8'($urandom_range(0, 255)));
        else if (k == 3) return enc_mov(r2, s, r3);
        else if (k <= 6) return enc_alu(o, r1, r2, s, r3);
        else if (k == 7) return enc_ldr(r1, r2, 5'($urandom_range(0, 31)));
        else if (k == 8) return enc_str(r1, r2, 5'($urandom_range(0, 31)));
        else             return enc_alu(2'b00, r1, r2, s, r3);
    endfunction

    task automatic load(input int addr, input logic [15:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    function automatic int to_signed(input logic [15:0] v);
        return (int'(v) >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic logic [15:0] shift_val(input logic [15:0] v, input logic [1:0] s);
        int x;
        x = int'(v);
        case (s)
            2'd1:    return 16'((x * 2) % 65536);
            2'd2:    return 16'(x / 2);
            2'd3:    return 16'((x / 2) + ((x >= 32768) ? 32768 : 0));
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        ref_pc   = 0;
        ref_c    = 16'd0;
        ref_z    = 3'd0;
        ref_halt = 1'b0;
    endtask

    // Executes one instruction at ref_pc; returns its class, length in cycles and data access.
    task automatic model_step(output int kind, output int ncyc, output int daddr, output logic [15:0] sdata);
        logic [15:0] ins, sv, av;
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, s;
        int          imm5, diff, res;
        ins  = ref_mem[ref_pc];
        opc  = ins[15:13];
        op   = ins[12:11];
        rn   = ins[10:8];
        rd   = ins[7:5];
        s    = ins[4:3];
        rm   = ins[2:0];
        imm5 = (int'(ins[4:0]) >= 16) ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
        ref_pc = (ref_pc + 1) % 512;
        daddr  = 0;
        sdata  = 16'd0;
        if (opc == 3'b110 && op == 2'b10) begin
            kind = K_MOVI; ncyc = 5;
            ref_regs[rn] = 16'((int'(ins[7:0]) >= 128) ? int'(ins[7:0]) - 256 : int'(ins[7:0]));
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            kind = K_ALU; ncyc = 8;
            sv = shift_val(ref_regs[rm], s);
            av = ref_regs[rn];
            if (opc == 3'b110) ref_c = sv;
            else begin
                case (op)
                    2'b00: ref_c = 16'((int'(av) + int'(sv)) % 65536);
                    2'b01: begin
                        diff  = to_signed(av) - to_signed(sv);
                        res   = (diff + 65536) % 65536;
                        ref_c = 16'(res);
                        ref_z = {(diff > 32767 || diff < -32768), (res >= 32768), (res == 0)};
                    end
                    2'b10: ref_c = av & sv;
                    default: ref_c = 16'(65535 - int'(sv));
                endcase
            end
            if (!(opc == 3'b101 && op == 2'b01)) ref_regs[rd] = ref_c;
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            ncyc  = 8;
            res   = int'(ref_regs[rn]) + imm5;
            daddr = ((res % 512) + 512) % 512;
            if (opc == 3'b011) begin
                kind  = K_LDR;
                ref_c = 16'(((res % 65536) + 65536) % 65536);
                ref_regs[rd] = ref_mem[daddr];
            end else begin
                kind  = K_STR;
                sdata = ref_regs[rd];
                ref_c = sdata;
                ref_mem[daddr] = sdata;
            end
        end else begin
            kind = K_HALT; ncyc = 4;
            ref_halt = 1'b1;
        end
    endtask

    // Starts at the first fetch cycle; checks the bus every cycle, then C/status/halt.
    task automatic run_instr();
        int kind, ncyc, daddr, fetch_pc, exp_addr;
        logic [15:0] sdata;
        logic [1:0]  exp_cmd;
        fetch_pc = ref_pc;
        model_step(kind, ncyc, daddr, sdata);
        for (int k = 0; k < ncyc; k++) begin
            exp_cmd  = (k < 2) ? 2'b01 : 2'b00;
            exp_addr = (k < 3) ? fetch_pc : (fetch_pc + 1) % 512;
            if (kind == K_LDR && k >= 6) begin
                exp_cmd = 2'b01; exp_addr = daddr;
            end
            if (kind == K_STR && k == 7) begin
                exp_cmd = 2'b10; exp_addr = daddr;
                check("store_data", write_data, sdata);
            end
            check("bus_mem_cmd", 16'(mem_cmd), 16'(exp_cmd));
            check("bus_mem_addr", 16'(mem_addr), 16'(exp_addr));
            if (mem_cmd == 2'b10) mem[mem_addr] = write_data;
            @(negedge clk);
        end
        check("result_c", write_data, ref_c);
        check("status_z", 16'(dut.Z), 16'(ref_z));
        check("haltled", 16'(HALTLED), 16'(ref_halt));
        if (kind == K_HALT) check("halt_mem_cmd", 16'(mem_cmd), 16'd0);
    endtask

    task automatic run_expect(input string tag, input logic [15:0] exp_wd);
        run_instr();
        check(tag, write_data, exp_wd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("rst_haltled", 16'(HALTLED), 16'd0);
        check("rst_status", 16'(dut.Z), 16'd0);
        check("rst_write_data", write_data, 16'd0);
        check("rst_mem_cmd", 16'(mem_cmd), 16'd0);
        check("rst_mem_addr", 16'(mem_addr), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_fetch_cmd", 16'(mem_cmd), 16'd1);
        check("first_fetch_addr", 16'(mem_addr), 16'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int i = 0; i < 512; i++) load(i, 16'hE000);

        // Directed program
        load(0,  enc_movi(3'd0, 8'd1));
        load(1,  enc_movi(3'd1, 8'hF9));
        load(2,  enc_movi(3'd2, 8'd5));
        load(3,  enc_alu(2'b00, 3'd0, 3'd3, 2'd0, 3'd1));
        load(4,  enc_alu(2'b00, 3'd0, 3'd4, 2'd0, 3'd2));
        load(5,  enc_alu(2'b00, 3'd1, 3'd5, 2'd1, 3'd2));
        load(6,  enc_mov(3'd1, 2'd2, 3'd5));
        load(7,  enc_alu(2'b10, 3'd4, 3'd6, 2'd1, 3'd3));
        load(8,  enc_movi(3'd0, 8'd3));
        load(9,  enc_alu(2'b01, 3'd0, 3'd0, 2'd0, 3'd5));
        load(10, enc_alu(2'b01, 3'd3, 3'd0, 2'd0, 3'd4));
        load(11, enc_movi(3'd7, 8'd100));
        load(12, enc_ldr(3'd7, 3'd7, 5'd0));
        load(13, enc_alu(2'b01, 3'd7, 3'd0, 2'd0, 3'd1));
        load(14, enc_movi(3'd6, 8'd0));
        load(15, enc_alu(2'b11, 3'd0, 3'd7, 2'd0, 3'd6));
        load(16, enc_movi(3'd0, 8'd1));
        load(17, enc_str(3'd0, 3'd2, 5'd2));
        load(18, enc_ldr(3'd0, 3'd4, 5'd2));
        load(19, enc_mov(3'd5, 2'd0, 3'd4));
        load(20, 16'hE000);
        load(100, 16'h8000);

        do_reset();
        run_instr(); run_instr(); run_instr();
        run_expect("add_r3", 16'hFFFA);
        run_expect("add_r4", 16'h0006);
        run_expect("add_lsl", 16'h0003);
        run_expect("mov_lsr", 16'h0001);
        run_expect("and_lsl", 16'h0004);
        run_instr();
        run_instr(); check("cmp_equal", 16'(dut.Z), 16'b001);
        run_instr(); check("cmp_negative", 16'(dut.Z), 16'b010);
        run_instr();
        run_expect("ldr_8000_addr", 16'd100);
        run_instr(); check("cmp_overflow", 16'(dut.Z), 16'b100);
        run_instr();
        run_expect("mvn_zero", 16'hFFFF);
        run_instr();
        run_instr(); check("str_mem3", mem[3], 16'h0005);
        load(3, 16'h1234);
        run_instr();
        run_expect("ldr_r4_via_mov", 16'h1234);
        run_instr();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("halt_hold_led", 16'(HALTLED), 16'd1);
            check("halt_pc_frozen", 16'(mem_addr), 16'd21);
        end

        // Reset in the write-back cycle of an ADD
        load(0, enc_movi(3'd1, 8'd3));
        load(1, enc_movi(3'd2, 8'd4));
        load(2, enc_alu(2'b00, 3'd1, 3'd3, 2'd0, 3'd2));
        do_reset();
        run_instr(); run_instr();
        repeat (7) @(negedge clk);
        check("pre_abort_c", write_data, 16'd7);
        load(0, enc_str(3'd0, 3'd3, 5'd10));
        load(1, 16'hE000);
        do_reset();
        run_expect("abort_no_write", 16'd0);
        run_instr();

        // Unrecognised encoding halts
        load(0, 16'h4800);
        do_reset();
        run_instr();
        check("invalid_halts", 16'(HALTLED), 16'd1);

        // Random programs
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 512; i++) load(i, rand_instr());
            do_reset();
            for (int i = 0; i < 250 && !ref_halt; i++) run_instr();
        end

        // Program counter wrap 511 -> 0
        for (int i = 0; i < 512; i++) load(i, enc_movi(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))));
        do_reset();
        n = 0;
        while (n < 515) begin
            run_instr();
            n++;
        end
        check("pc_wrapped", 16'(mem_addr), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
